regfile_scoreboard: RTL and testbench

- Parametrised integer register file for the pipelined core.
- Combinational read ports, one synchronous write port, optional write-to-read bypass.
- Per-register busy (scoreboard) bits: set when decode claims a destination, cleared on writeback.
- Sits between decode (read/claim) and writeback (write). Register 0 is hard-wired zero and never busy.

---
 rtl/regfile_scoreboard.sv | 107 ++++++++++
 tb/tb_regfile_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Integer register file with combinational reads, a single
//               synchronous write port and per-register busy scoreboard bits.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [ADDR_W:0]   busy_count,
    output logic              err_unclaimed
);

    localparam int c_num_regs = 2 ** ADDR_W;

    logic [DATA_W-1:0]     mem_q [c_num_regs];
    logic [DATA_W-1:0]     mem_d [c_num_regs];
    logic [c_num_regs-1:0] busy_q;
    logic [c_num_regs-1:0] busy_d;
    logic [ADDR_W:0]       busy_count_q;
    logic [ADDR_W:0]       busy_count_d;
    logic                  err_unclaimed_q;
    logic                  err_unclaimed_d;

    logic w_wr_hit;
    logic w_claim_hit;
    logic w_rs1_fwd;
    logic w_rs2_fwd;

    assign w_wr_hit    = wr_en && (wr_addr != '0);
    assign w_claim_hit = claim_en && (claim_addr != '0);

    // Claim is applied after the write clear so a same-edge re-claim wins.
    always_comb begin
        mem_d           = mem_q;
        busy_d          = busy_q;
        err_unclaimed_d = err_unclaimed_q;
        busy_count_d    = '0;
        if (w_wr_hit) begin
            mem_d[wr_addr]  = wr_data;
            busy_d[wr_addr] = 1'b0;
            if (!busy_q[wr_addr]) begin
                err_unclaimed_d = 1'b1;
            end
        end
        if (w_claim_hit) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        for (int i = 0; i < c_num_regs; i++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_regs; i++) begin
                mem_q[i] <= '0;
            end
            busy_q          <= '0;
            busy_count_q    <= '0;
            err_unclaimed_q <= 1'b0;
        end else begin
            for (int i = 0; i < c_num_regs; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q          <= busy_d;
            busy_count_q    <= busy_count_d;
            err_unclaimed_q <= err_unclaimed_d;
        end
    end

    // Forwarding is gated by rst_n so reads show the cleared state in reset.
    if (BYPASS != 0) begin : g_bypass
        assign w_rs1_fwd = rst_n && w_wr_hit && (wr_addr == rs1_addr);
        assign w_rs2_fwd = rst_n && w_wr_hit && (wr_addr == rs2_addr);
    end else begin : g_no_bypass
        assign w_rs1_fwd = 1'b0;
        assign w_rs2_fwd = 1'b0;
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : (w_rs1_fwd ? wr_data : mem_q[rs1_addr]);
    assign rs1_busy = (rs1_addr == '0) ? 1'b0 : (w_rs1_fwd ? 1'b0 : busy_q[rs1_addr]);
    assign rs2_data = (rs2_addr == '0) ? '0 : (w_rs2_fwd ? wr_data : mem_q[rs2_addr]);
    assign rs2_busy = (rs2_addr == '0) ? 1'b0 : (w_rs2_fwd ? 1'b0 : busy_q[rs2_addr]);

    assign busy_count    = busy_count_q;
    assign err_unclaimed = err_unclaimed_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed plus random checks of regfile_scoreboard (BYPASS=1
//               and BYPASS=0 instances) against an array-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, claim_addr;
    logic        wr_en, claim_en;
    logic [31:0] wr_data;

    logic [31:0] rs1_data_b, rs2_data_b, rs1_data_n, rs2_data_n;
    logic        rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;
    logic [5:0]  busy_count_b, busy_count_n;
    logic        err_b, err_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model_mem  [32];
    logic        model_busy [32];
    logic        model_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data_b), .rs1_busy(rs1_busy_b),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data_b), .rs2_busy(rs2_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_count(busy_count_b), .err_unclaimed(err_b)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data_n), .rs1_busy(rs1_busy_n),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data_n), .rs2_busy(rs2_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_count(busy_count_n), .err_unclaimed(err_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            model_mem[i]  = 32'h0;
            model_busy[i] = 1'b0;
        end
        model_err = 1'b0;
    endtask

    // Expected read value seen by an instance with or without forwarding.
    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && rst_n && wr_en && wr_addr == a) return wr_data;
        return model_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && rst_n && wr_en && wr_addr == a) return 32'h0;
        return {31'h0, model_busy[a]};
    endfunction

    function automatic logic [31:0] exp_count();
        int s = 0;
        for (int i = 1; i < 32; i++) s += model_busy[i] ? 1 : 0;
        return s;
    endfunction

    task automatic model_edge();
        if (!rst_n) return;
        if (wr_en && wr_addr != 0) begin
            if (!model_busy[wr_addr]) model_err = 1'b1;
            model_mem[wr_addr]  = wr_data;
            model_busy[wr_addr] = 1'b0;
        end
        if (claim_en && claim_addr != 0) model_busy[claim_addr] = 1'b1;
    endtask

    task automatic check_comb();
        chk("byp_rs1_data",   rs1_data_b,          exp_data(rs1_addr, 1'b1));
        chk("byp_rs1_busy",   {31'h0, rs1_busy_b}, exp_busy(rs1_addr, 1'b1));
        chk("byp_rs2_data",   rs2_data_b,          exp_data(rs2_addr, 1'b1));
        chk("byp_rs2_busy",   {31'h0, rs2_busy_b}, exp_busy(rs2_addr, 1'b1));
        chk("nobyp_rs1_data", rs1_data_n,          exp_data(rs1_addr, 1'b0));
        chk("nobyp_rs1_busy", {31'h0, rs1_busy_n}, exp_busy(rs1_addr, 1'b0));
        chk("nobyp_rs2_data", rs2_data_n,          exp_data(rs2_addr, 1'b0));
        chk("nobyp_rs2_busy", {31'h0, rs2_busy_n}, exp_busy(rs2_addr, 1'b0));
    endtask

    task automatic check_reg();
        chk("byp_busy_count",   {26'h0, busy_count_b}, exp_count());
        chk("nobyp_busy_count", {26'h0, busy_count_n}, exp_count());
        chk("byp_err",          {31'h0, err_b},        {31'h0, model_err});
        chk("nobyp_err",        {31'h0, err_n},        {31'h0, model_err});
    endtask

    // Inputs are set by the caller ~1 time unit after an edge.
    task automatic cycle();
        #3;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_reg();
    endtask

    task automatic idle();
        wr_en = 1'b0; claim_en = 1'b0;
    endtask

    task automatic do_reset_pulse();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_comb();
        check_reg();
        @(posedge clk);
        #1;
        check_comb();
        check_reg();
        idle();
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            rs1_addr   = rand_addr();
            rs2_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : rand_addr();
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_addr    = rand_addr();
            wr_data    = $urandom;
            claim_en   = ($urandom_range(0, 1) != 0);
            claim_addr = ($urandom_range(0, 5) == 0) ? wr_addr : rand_addr();
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; claim_addr = '0;
        wr_data = '0; wr_en = 1'b0; claim_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_comb();
        check_reg();
        rst_n = 1'b1;

        // claim x7, observe busy, write with forwarding, then stored value
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        claim_en = 1'b1; claim_addr = 5'd7;
        cycle();
        idle();
        cycle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
        cycle();
        idle();
        cycle();

        // x0 protection
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        claim_en = 1'b1; claim_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        cycle();
        idle();
        cycle();

        // same-edge claim and write to a busy x3: claim wins
        rs1_addr = 5'd3; rs2_addr = 5'd0;
        claim_en = 1'b1; claim_addr = 5'd3;
        cycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_A5A5;
        cycle();
        idle();
        cycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0077;
        cycle();
        idle();
        cycle();

        // unclaimed write to x9 sets the sticky error
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0055;
        cycle();
        idle();
        repeat (3) cycle();

        // write x5, then async reset while enables are still active
        rs1_addr = 5'd5; rs2_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        cycle();
        idle();
        cycle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE_F00D;
        claim_en = 1'b1; claim_addr = 5'd6;
        do_reset_pulse();
        cycle();

        random_cycles(300);
        idle();
        do_reset_pulse();
        random_cycles(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
